// File: rtl/riscv_pkg.sv
// Shared encodings and decode helpers for the memory-stage load/store unit.
package riscv_pkg;

    typedef enum logic [2:0] {
        SIZE_B  = 3'b000,
        SIZE_H  = 3'b001,
        SIZE_W  = 3'b010,
        SIZE_BU = 3'b100,
        SIZE_HU = 3'b101
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10,
        DONE = 2'b11
    } lsu_state_t;

    localparam logic [1:0] WIDTH_B = 2'b00;
    localparam logic [1:0] WIDTH_H = 2'b01;
    localparam logic [1:0] WIDTH_W = 2'b10;

    // Stores ignore the unsigned bit; any undefined code falls back to a byte access.
    function automatic logic [1:0] access_width(input logic [2:0] size, input logic is_store);
        logic [2:0] code;
        code = is_store ? {1'b0, size[1:0]} : size;
        case (code)
            SIZE_B, SIZE_BU: return WIDTH_B;
            SIZE_H, SIZE_HU: return WIDTH_H;
            SIZE_W:          return WIDTH_W;
            default:         return WIDTH_B;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lo);
        case (width)
            WIDTH_H: return lo[0];
            WIDTH_W: return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_unsigned(input logic [2:0] size);
        return (size == SIZE_BU) || (size == SIZE_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables and store replication on the way out,
// load extraction and sign/zero extension on the way back.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  st_addr_lo,
    input  logic [1:0]  st_width,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_addr_lo,
    input  logic [1:0]  ld_width,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift_s;

    // Byte enables and lane-replicated store data for the outgoing request
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = 32'h0000_0000;
        case (st_width)
            WIDTH_H: begin
                st_be    = 4'b0011 << {st_addr_lo[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            WIDTH_W: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
            default: begin
                st_be    = 4'b0001 << st_addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
        endcase
    end

    // Align the addressed bytes to bit 0 and extend to 32 bits
    always_comb begin
        ld_shift_s = ld_word >> {ld_addr_lo, 3'b000};
        ld_data    = 32'h0000_0000;
        case (ld_width)
            WIDTH_H: begin
                if (ld_unsigned) begin
                    ld_data = {16'h0000, ld_shift_s[15:0]};
                end else begin
                    ld_data = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
                end
            end
            WIDTH_W: begin
                ld_data = ld_shift_s;
            end
            default: begin
                if (ld_unsigned) begin
                    ld_data = {24'h00_0000, ld_shift_s[7:0]};
                end else begin
                    ld_data = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
                end
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one word-aligned req/gnt + rvalid transaction
// per instruction, with misalignment rejection and a bus timeout.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [2:0]  size_src,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 32'd2) ? 32'd1 : $clog2(TIMEOUT_CYCLES + 32'd1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic TMO_EN = (TIMEOUT_CYCLES != 32'd0);

    lsu_state_t       state_r, state_s;
    logic             access_s, accept_s, reject_s, capture_s, timeout_s, stall_s, busy_s;
    logic             misalign_s;
    logic [1:0]       width_s;
    logic [3:0]       st_be_s;
    logic [31:0]      st_wdata_s, ld_data_s;
    logic [CNT_W-1:0] cnt_r;

    logic             we_r, uns_r;
    logic [1:0]       width_r, addr_lo_r;
    logic [31:0]      addr_r, wdata_r, rdata_r;
    logic [3:0]       be_r;
    logic             done_r, mem_req_r, misaligned_r, bus_err_r;

    lsu_align u_align (
        .st_addr_lo  (addr[1:0]),
        .st_width    (width_s),
        .st_data     (wdata),
        .st_be       (st_be_s),
        .st_wdata    (st_wdata_s),
        .ld_addr_lo  (addr_lo_r),
        .ld_width    (width_r),
        .ld_unsigned (uns_r),
        .ld_word     (mem_rdata),
        .ld_data     (ld_data_s)
    );

    // Classify the incoming instruction and detect the bus timeout
    always_comb begin
        access_s   = req_valid & (mem_write | mem_read);
        width_s    = access_width(size_src, mem_write);
        misalign_s = is_misaligned(width_s, addr[1:0]);
        busy_s     = (state_r == REQ) || (state_r == RESP);
        if (state_r == IDLE) begin
            accept_s = access_s & ~misalign_s;
            reject_s = access_s & misalign_s;
        end else begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end
        if (busy_s && TMO_EN && (cnt_r == TMO_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Next-state, stall and response-capture decode; timeout overrides the bus
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        stall_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = REQ;
                    stall_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                stall_s = 1'b1;
                if (timeout_s) begin
                    state_s = DONE;
                end else if (mem_gnt && mem_rvalid) begin
                    state_s   = DONE;
                    capture_s = 1'b1;
                end else if (mem_gnt) begin
                    state_s = RESP;
                end else begin
                    state_s = REQ;
                end
            end
            RESP: begin
                stall_s = 1'b1;
                if (timeout_s) begin
                    state_s = DONE;
                end else if (mem_rvalid) begin
                    state_s   = DONE;
                    capture_s = 1'b1;
                end else begin
                    state_s = RESP;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Timeout counter: runs while a transaction is on the bus, clears otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (busy_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= '0;
        end
    end

    // Latch the request on acceptance so the bus sees stable values until gnt
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r      <= 1'b0;
            uns_r     <= 1'b0;
            width_r   <= 2'b00;
            addr_lo_r <= 2'b00;
            addr_r    <= 32'h0000_0000;
            be_r      <= 4'b0000;
            wdata_r   <= 32'h0000_0000;
        end else if (accept_s) begin
            we_r      <= mem_write;
            uns_r     <= is_unsigned(size_src) & ~mem_write;
            width_r   <= width_s;
            addr_lo_r <= addr[1:0];
            addr_r    <= {addr[31:2], 2'b00};
            be_r      <= st_be_s;
            wdata_r   <= st_wdata_s;
        end else begin
            we_r      <= we_r;
            uns_r     <= uns_r;
            width_r   <= width_r;
            addr_lo_r <= addr_lo_r;
            addr_r    <= addr_r;
            be_r      <= be_r;
            wdata_r   <= wdata_r;
        end
    end

    // Registered status pulses, bus request and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r       <= 1'b0;
            mem_req_r    <= 1'b0;
            misaligned_r <= 1'b0;
            bus_err_r    <= 1'b0;
            rdata_r      <= 32'h0000_0000;
        end else begin
            done_r       <= (state_s == DONE);
            mem_req_r    <= (state_s == REQ);
            misaligned_r <= reject_s;
            bus_err_r    <= timeout_s;
            if (capture_s) begin
                rdata_r <= we_r ? 32'h0000_0000 : ld_data_s;
            end else if (state_r == DONE) begin
                rdata_r <= rdata_r;
            end else begin
                rdata_r <= 32'h0000_0000;
            end
        end
    end

    assign stall      = stall_s;
    assign done       = done_r;
    assign rdata      = rdata_r;
    assign misaligned = misaligned_r;
    assign bus_err    = bus_err_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_req_r & we_r;
    assign mem_addr   = addr_r;
    assign mem_be     = be_r;
    assign mem_wdata  = wdata_r;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage load/store unit that consumes the decoder's memWrite, load indication and 3-bit sizeSrc, together with the ALU address and rs2 data.
It issues one word-aligned request per instruction to the data-memory port using a req/gnt then rvalid handshake, and generates byte enables and store-data lane replication.
Returned load data is extracted and sign- or zero-extended.
It stalls the pipeline while an access is outstanding, and flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, number of cycles in REQ+RESP before a bus error is declared; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  memory instruction present this cycle; held stable while stall=1
mem_write  in  1  store (decoder memWrite)
mem_read  in  1  load (decoder resultSrc==2'b01)
size_src  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
addr  in  32  effective byte address
wdata  in  32  store data (rs2)
stall  out  1  freeze upstream pipeline
done  out  1  one-cycle pulse, access complete
rdata  out  32  extended load result, valid with done
misaligned  out  1  one-cycle pulse, access rejected for misalignment
bus_err  out  1  one-cycle pulse with done on timeout
mem_req  out  1  request to memory
mem_we  out  1  write request
mem_addr  out  32  {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  response/ack valid
mem_rdata  in  32  read word

Behaviour:
- Reset: state IDLE. stall, done, misaligned, bus_err, mem_req, mem_we = 0. rdata, mem_addr, mem_be, mem_wdata = 0. Timeout counter = 0.
- Access classification:
  - Access = req_valid & (mem_write | mem_read). If both are high, the access is a store.
  - Width = size_src[1:0]. Undefined codes 011/110/111 are treated as a byte access. Stores ignore size_src[2].
- Misalignment:
  - Half access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]!=0 is misaligned.
  - A misaligned access in IDLE produces: misaligned=1 the next cycle, no memory request, stall=0, rdata=0, state stays IDLE.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE with an aligned access: latch op, address, be, wdata and size, then go to REQ. stall is combinationally 1 in that same cycle.
  - REQ: mem_req=1, outputs held stable until gnt.
    - gnt & rvalid together: go to DONE (zero-wait memory).
    - gnt only: go to RESP.
  - RESP: mem_req=0. On rvalid, register the extended rdata and go to DONE.
  - DONE: done=1, stall=0 for one cycle, then IDLE. req_valid is ignored in DONE, because it is still the same instruction. The next access is accepted in IDLE.
  - stall = (IDLE & aligned access) | REQ | RESP.
- Latency: with gnt in the first REQ cycle and rvalid the next cycle, done occurs 3 cycles after acceptance, stalling 3 cycles. With gnt and rvalid together, done occurs 2 cycles after acceptance.
- Byte enables:
  - b: 0001<<addr[1:0]
  - h: 0011<<{addr[1],1'b0}
  - w: 1111
- Store data: mem_wdata is the byte replicated x4, the half replicated x2, or the full word.
- Load extraction:
  - Shift mem_rdata right by 8*addr[1:0].
  - b / h: sign-extend bit 7 / bit 15.
  - bu / hu: zero-extend.
- Stores also wait for rvalid (write ack). rdata is 0 for stores.
- Timeout:
  - The counter increments every cycle in REQ/RESP and clears in IDLE.
  - Reaching TIMEOUT_CYCLES forces DONE with bus_err=1, rdata=0, and mem_req dropped.
  - Any later rvalid is ignored.
- mem_rvalid and mem_gnt are ignored outside REQ/RESP.
- Reset mid-access: return to IDLE, mem_req drops in the next cycle, stale responses are ignored.

Decomposition:
- Package riscv_pkg: size_t encodings SIZE_B=000, SIZE_H=001, SIZE_W=010, SIZE_BU=100, SIZE_HU=101; lsu_state_t enum {IDLE, REQ, RESP, DONE}.
- Combinational sub-module lsu_align: be/wdata generation and load extraction/extension, reused on both paths.

Test Plan:
- sw addr=0x100 wdata=0xDEADBEEF, gnt on cycle 1, rvalid on cycle 2 -> mem_be=1111, mem_addr=0x100, mem_we=1, stall 3 cycles, done pulse.
- sb addr=0x103 wdata=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- lb addr=0x102 with mem_rdata=0x0080FF00 -> rdata=0xFFFFFF80. Same access as lbu -> rdata=0x00000080.
- lh addr=0x101 -> misaligned pulse, mem_req never asserted, stall=0. lhu addr=0x102 with mem_rdata=0x8001_0000 -> rdata=0x00008001.
- lw with gnt and rvalid in the same REQ cycle -> done 2 cycles after acceptance. lw with gnt withheld 5 cycles -> mem_req and mem_addr held stable throughout.
- TIMEOUT_CYCLES=4, no gnt -> bus_err and done on the 4th REQ cycle, rdata=0. rst asserted while in RESP -> IDLE next cycle, a later rvalid produces no done.
